// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS-style core:
//   - primary opcode constants and instruction-type classification
//   - arbiter FSM state encoding (mem_port_arbiter)
//   - memory-port owner encoding (OWN_IF = 0, OWN_D = 1)
// No ports; imported with "import mips_pkg::*;".
// -----------------------------------------------------------------------------
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ITYPE_R = 2'd0,
    ITYPE_I = 2'd1,
    ITYPE_J = 2'd2
  } itype_e;

  // Instruction format from the primary opcode.
  function automatic itype_e opcode_type(input logic [5:0] op);
    itype_e t;
    t = ITYPE_I;
    case (op)
      OP_RTYPE: t = ITYPE_R;
      OP_J:     t = ITYPE_J;
      default:  t = ITYPE_I;
    endcase
    return t;
  endfunction

  // Memory-port arbiter states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  // Memory-port owner
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Combinational two-way round-robin pick between the fetch and data ports.
// Ports:
//   i_req_if     - fetch port eligible request
//   i_req_d      - data port eligible request
//   i_last_owner - owner of the most recent grant
//   o_any        - at least one request present
//   o_winner     - selected owner (only meaningful when o_any = 1)
// -----------------------------------------------------------------------------
module arb_rr2
  import mips_pkg::*;
(
  input  logic   i_req_if,
  input  logic   i_req_d,
  input  owner_e i_last_owner,
  output logic   o_any,
  output owner_e o_winner
);

  assign o_any = i_req_if | i_req_d;

  always_comb begin
    // NOTE: assign a default before any branch so every path drives o_winner;
    // otherwise a latch is inferred.
    o_winner = OWN_IF;
    if (i_req_if && i_req_d) begin
      // Contention: the port that did not own the last grant goes next.
      o_winner = (i_last_owner == OWN_IF) ? OWN_D : OWN_IF;
    end else if (i_req_d) begin
      o_winner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between an instruction-fetch port and a
// data port. Each access runs IDLE -> ACCESS -> WAIT (WAIT_CYCLES) -> RESP,
// giving a fixed issue period of WAIT_CYCLES+3 cycles. All outputs registered.
// Ports:
//   i_clk1, i_rst                    - clock, synchronous active-high reset
//   i_halt                           - masks fetch requests while high
//   i_if_req/i_if_addr               - fetch request (held until o_if_gnt)
//   o_if_gnt/o_if_valid/o_if_rdata   - fetch grant, response pulse, data
//   i_d_req/i_d_we/i_d_addr/i_d_wdata- data request (held until o_d_gnt)
//   o_d_gnt/o_d_valid/o_d_rdata      - data grant, response pulse, load data
//   o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata/i_mem_rdata - memory side
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2   // legal 1..7
) (
  input  logic              i_clk1,
  input  logic              i_rst,
  input  logic              i_halt,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_valid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES - 1);

  arb_state_e        r_state;
  owner_e            r_last_owner;   // also the owner of the access in flight
  logic [2:0]        r_wait_cnt;
  logic              r_is_store;
  logic              r_if_gnt, r_if_valid, r_d_gnt, r_d_valid;
  logic              r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;

  logic   w_if_elig;
  logic   w_any;
  owner_e w_winner;

  assign w_if_elig = i_if_req & ~i_halt;

  arb_rr2 u_arb (
    .i_req_if     (w_if_elig),
    .i_req_d      (i_d_req),
    .i_last_owner (r_last_owner),
    .o_any        (w_any),
    .o_winner     (w_winner)
  );

  // NOTE: state registers use non-blocking (<=) so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_clk1) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_last_owner <= OWN_IF;
      r_wait_cnt   <= '0;
      r_is_store   <= 1'b0;
      r_if_gnt     <= 1'b0;
      r_if_valid   <= 1'b0;
      r_d_gnt      <= 1'b0;
      r_d_valid    <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      // Grant, strobe and valid are single-cycle pulses.
      r_if_gnt   <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_mem_en   <= 1'b0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state      <= ST_ACCESS;
            r_last_owner <= w_winner;
            r_mem_en     <= 1'b1;
            // Request fields are captured here only; later changes are ignored.
            if (w_winner == OWN_D) begin
              r_d_gnt     <= 1'b1;
              r_is_store  <= i_d_we;
              r_mem_we    <= i_d_we;
              r_mem_addr  <= i_d_addr;
              r_mem_wdata <= i_d_wdata;
            end else begin
              r_if_gnt    <= 1'b1;
              r_is_store  <= 1'b0;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= i_if_addr;
              r_mem_wdata <= '0;
            end
          end
        end

        ST_ACCESS: begin
          r_state    <= ST_WAIT;
          r_wait_cnt <= WAIT_LOAD;
        end

        ST_WAIT: begin
          if (r_wait_cnt == 3'd0) begin
            // Edge ending the last wait cycle: capture read data into the
            // owner's holding register and raise its valid for RESP.
            r_state <= ST_RESP;
            if (r_last_owner == OWN_D) begin
              r_d_valid <= 1'b1;
              if (!r_is_store) r_d_rdata <= i_mem_rdata;
            end else begin
              r_if_valid <= 1'b1;
              r_if_rdata <= i_mem_rdata;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end

        ST_RESP: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_if_gnt    = r_if_gnt;
  assign o_if_valid  = r_if_valid;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_gnt     = r_d_gnt;
  assign o_d_valid   = r_d_valid;
  assign o_d_rdata   = r_d_rdata;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (WAIT_CYCLES = 2) with a behavioural
// synchronous memory and a response scoreboard.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int W      = 2;
  localparam int PERIOD = W + 3;

  logic              clk = 1'b0;
  logic              rst, halt;
  logic              if_req, d_req, d_we;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              o_if_gnt, o_if_valid, o_d_gnt, o_d_valid;
  logic [DATA_W-1:0] o_if_rdata, o_d_rdata;
  logic              o_mem_en, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit mon_on   = 1'b0;

  typedef struct {
    bit          is_d;
    bit          is_store;
    logic [31:0] data;      // expected rdata of the owning port in RESP
    int          exp_cyc;   // cycle in which valid must appear
  } sb_t;

  sb_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(W)) dut (
    .i_clk1      (clk),
    .i_rst       (rst),
    .i_halt      (halt),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_valid  (o_if_valid),
    .o_if_rdata  (o_if_rdata),
    .i_d_req     (d_req),
    .i_d_we      (d_we),
    .i_d_addr    (d_addr),
    .i_d_wdata   (d_wdata),
    .o_d_gnt     (o_d_gnt),
    .o_d_valid   (o_d_valid),
    .o_d_rdata   (o_d_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [9:0] a;
    a = 10'(i);
    return (i == 5) ? 32'h2000_0001 : {16'hC0DE, 6'b0, a};
  endfunction

  // Synchronous memory: read data appears the cycle after the strobe and holds.
  // Contents are (re)loaded while reset is high.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_rdata <= '0;
    end else if (o_mem_en) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      else          mem_rdata       <= mem[o_mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input bit is_d, input bit st, input logic [31:0] data, input int exp_cyc);
    sb_t e;
    e.is_d     = is_d;
    e.is_store = st;
    e.data     = data;
    e.exp_cyc  = exp_cyc;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pulses"}, {o_if_gnt, o_d_gnt, o_if_valid, o_d_valid, o_mem_en, o_mem_we}, 0);
    check({tag, "_if_rdata"}, o_if_rdata, 0);
    check({tag, "_d_rdata"}, o_d_rdata, 0);
    check({tag, "_mem_addr"}, o_mem_addr, 0);
    check({tag, "_mem_wdata"}, o_mem_wdata, 0);
  endtask

  // Monitor: per-cycle exclusivity and scoreboard pop on every valid pulse.
  always @(negedge clk) begin : mon
    sb_t e;
    if (mon_on && !rst) begin
      check("one_gnt", o_if_gnt & o_d_gnt, 0);
      check("one_valid", o_if_valid & o_d_valid, 0);
      check("strobe_with_gnt", o_mem_en, o_if_gnt | o_d_gnt);
      if (o_if_valid || o_d_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", {o_if_valid, o_d_valid}, 0);
        end else begin
          e = sb_q.pop_front();
          check("valid_port_is_d", o_d_valid, e.is_d);
          check("valid_cycle", cyc, e.exp_cyc);
          if (e.is_d) check("d_rdata", o_d_rdata, e.data);
          else        check("if_rdata", o_if_rdata, e.data);
        end
      end
    end
  end

  initial begin
    int c0;
    bit exp_d, exp_i;
    rst = 1'b1; halt = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset state
    tick(3);
    check_reset_outputs("rst");
    rst = 1'b0;
    mon_on = 1'b1;
    tick();

    // Single fetch from address 5
    c0 = cyc;
    if_req = 1'b1; if_addr = 10'd5;
    push(1'b0, 1'b0, 32'h2000_0001, c0 + 2 + W);
    tick();
    check("s1_if_gnt", o_if_gnt, 1);
    check("s1_mem_en", o_mem_en, 1);
    check("s1_mem_addr", o_mem_addr, 5);
    check("s1_mem_we", o_mem_we, 0);
    if_req = 1'b0; if_addr = 10'h123;  // post-grant changes must be ignored
    tick(W + 2);
    check("s1_if_rdata_hold", o_if_rdata, 32'h2000_0001);

    // Both ports held after reset: D, I, D, I
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c0 = cyc;
    if_req = 1'b1; if_addr = 10'd7;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9;
    for (int k = 0; k < 4; k++)
      push(k % 2 == 0, 1'b0, init_word((k % 2 == 0) ? 9 : 7), c0 + 2 + W + k * PERIOD);
    for (int t = 1; t <= 4 * PERIOD; t++) begin
      tick();
      exp_d = ((t - 1) % PERIOD == 0) && (((t - 1) / PERIOD) % 2 == 0) && (t <= 1 + 3 * PERIOD);
      exp_i = ((t - 1) % PERIOD == 0) && (((t - 1) / PERIOD) % 2 == 1) && (t <= 1 + 3 * PERIOD);
      check("s2_d_gnt", o_d_gnt, exp_d);
      check("s2_if_gnt", o_if_gnt, exp_i);
      if (t == 1 + 3 * PERIOD) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
    end

    // Store 0xDEADBEEF to 0x3FF, then load it back
    c0 = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h3FF; d_wdata = 32'hDEAD_BEEF;
    push(1'b1, 1'b1, init_word(9), c0 + 2 + W);
    tick();
    check("s3_st_gnt", o_d_gnt, 1);
    check("s3_st_we", o_mem_we, 1);
    check("s3_st_addr", o_mem_addr, 10'h3FF);
    check("s3_st_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0BAD_0BAD;
    tick(W + 2);
    check("s3_d_rdata_hold", o_d_rdata, init_word(9));
    c0 = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h3FF;
    push(1'b1, 1'b0, 32'hDEAD_BEEF, c0 + 2 + W);
    tick();
    check("s3_ld_gnt", o_d_gnt, 1);
    check("s3_ld_en", o_mem_en, 1);
    check("s3_ld_we", o_mem_we, 0);
    d_req = 1'b0;
    tick(W + 2);

    // Halt masks fetch; released fetch survives a later halt; data waits
    halt = 1'b1; if_req = 1'b1; if_addr = 10'd12;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("s4_halt_no_gnt", o_if_gnt, 0);
      check("s4_halt_no_en", o_mem_en, 0);
    end
    c0 = cyc;
    halt = 1'b0;
    push(1'b0, 1'b0, init_word(12), c0 + 2 + W);
    tick();
    check("s4_if_gnt", o_if_gnt, 1);
    if_req = 1'b0;
    halt = 1'b1;                         // rises mid-access
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd20;  // arrives outside IDLE
    push(1'b1, 1'b0, init_word(20), c0 + 1 + PERIOD + 1 + W);
    tick(W + 2);
    check("s4_d_waiting", o_d_gnt, 0);
    halt = 1'b0;
    tick();
    check("s4_d_gnt", o_d_gnt, 1);
    d_req = 1'b0;
    tick(W + 2);

    // Reset during the first WAIT cycle of a load, then re-issue
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd30;
    tick();
    check("s5_gnt", o_d_gnt, 1);
    d_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("s5_rst");
    rst = 1'b0;
    tick(W + 2);
    check("s5_no_valid", o_d_valid, 0);
    c0 = cyc;
    d_req = 1'b1;
    push(1'b1, 1'b0, init_word(30), c0 + 2 + W);
    tick();
    check("s5_reissue_gnt", o_d_gnt, 1);
    d_req = 1'b0;
    tick(W + 3);

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
